// File: rtl/pwm_multi_channel_if.sv
// Register access bundle for the multi-channel PWM block.
// The write and read ports share one address map. rdata is registered by the slave.
interface pwm_multi_channel_if #(
  parameter int AW    = 4,
  parameter int CNT_W = 16
);
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [CNT_W-1:0] wdata;
  logic [AW-1:0]    raddr;
  logic [CNT_W-1:0] rdata;

  modport master (output wen, waddr, wdata, raddr, input rdata);
  modport slave  (input wen, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator.
// Each channel has the following features:
//   - a frame counter;
//   - double-buffered period and duty registers;
//   - one-shot mode;
//   - a frame-done pulse.
// A shared register port feeds all channels, and a global resync input restarts every running channel.

// One PWM channel: control/shadow registers, active registers, counter and output.
module pwm_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_ctrl,
  input  logic             wr_per,
  input  logic             wr_duty,
  input  logic [CNT_W-1:0] wdata,
  input  logic             sync_start,
  output logic [3:0]       ctrl,
  output logic [CNT_W-1:0] sh_per,
  output logic [CNT_W-1:0] sh_duty,
  output logic             pwm_out,
  output logic             frame_done
);
  localparam logic [CNT_W:0]   ONE_W = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] INC   = CNT_W'(1);

  logic             run;          // counting starts one cycle after enable lands
  logic [CNT_W-1:0] act_per, act_duty, cnt;
  logic [CNT_W:0]   p, d, c, s;
  logic             live, wrap, sync, load, active;
  logic [3:0]       wctrl;

  // Frame bookkeeping and active-window decode, all one bit wider than the counter
  always_comb begin
    p      = {1'b0, act_per};
    d      = {1'b0, act_duty};
    c      = {1'b0, cnt};
    s      = (p - d) >> 1;
    wctrl  = 4'(wdata);
    live   = ctrl[0] && run;
    sync   = sync_start && live;
    wrap   = live && (p != '0) && (c == p - ONE_W);
    load   = !live || wrap || sync;
    active = 1'b0;
    if (p == '0 || d == '0) active = 1'b0;
    else if (d >= p)        active = 1'b1;
    else if (ctrl[2])       active = (c >= s) && (c < s + d);
    else                    active = (c < d);
  end

  // Register file, counter and registered output; resync outranks the frame wrap
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ctrl       <= '0;
      sh_per     <= '0;
      sh_duty    <= '0;
      act_per    <= '0;
      act_duty   <= '0;
      cnt        <= '0;
      run        <= 1'b0;
      pwm_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (wr_ctrl)                      ctrl <= wctrl;
      else if (wrap && !sync && ctrl[3]) ctrl <= {ctrl[3:1], 1'b0};
      if (wr_per)  sh_per  <= wdata;
      if (wr_duty) sh_duty <= wdata;
      if (load) begin
        act_per  <= sh_per;
        act_duty <= sh_duty;
      end
      run <= ctrl[0];
      if (!live || sync || wrap || p == '0) cnt <= '0;
      else                                  cnt <= cnt + INC;
      frame_done <= wrap && !sync;
      pwm_out    <= live ? (active ^ ctrl[1]) : ctrl[1];
    end
  end
endmodule

// Top: address decode, per-channel instances, registered readback.
module pwm_multi_channel #(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 16,
  localparam int AW     = $clog2(NUM_CH) + 2
) (
  input  logic                clk,
  input  logic                n_rst,
  pwm_multi_channel_if.slave  bus,
  input  logic                sync_start,
  output logic [NUM_CH-1:0]   pwm_out,
  output logic [NUM_CH-1:0]   frame_done
);
  logic [NUM_CH-1:0][3:0]       ctrl_all;
  logic [NUM_CH-1:0][CNT_W-1:0] per_all, duty_all;
  logic [NUM_CH-1:0]            wr_ctrl, wr_per, wr_duty;
  logic [CNT_W-1:0]             rd_next;
  logic [1:0]                   wsel, rsel;
  int                           wch, rch;

  // Split addresses into channel index and register select
  always_comb begin
    wch  = int'(bus.waddr >> 2);
    rch  = int'(bus.raddr >> 2);
    wsel = bus.waddr[1:0];
    rsel = bus.raddr[1:0];
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Per-channel write strobes; reserved select and out-of-range channels match nothing
    always_comb begin
      wr_ctrl[i] = bus.wen && (wch == i) && (wsel == 2'd0);
      wr_per[i]  = bus.wen && (wch == i) && (wsel == 2'd1);
      wr_duty[i] = bus.wen && (wch == i) && (wsel == 2'd2);
    end

    pwm_ch #(.CNT_W(CNT_W)) u_ch (
      .clk        (clk),
      .n_rst      (n_rst),
      .wr_ctrl    (wr_ctrl[i]),
      .wr_per     (wr_per[i]),
      .wr_duty    (wr_duty[i]),
      .wdata      (bus.wdata),
      .sync_start (sync_start),
      .ctrl       (ctrl_all[i]),
      .sh_per     (per_all[i]),
      .sh_duty    (duty_all[i]),
      .pwm_out    (pwm_out[i]),
      .frame_done (frame_done[i])
    );
  end

  // Readback mux: CTRL, shadow period, shadow duty; everything else reads 0
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rch == i) begin
        case (rsel)
          2'd0:    rd_next = CNT_W'(ctrl_all[i]);
          2'd1:    rd_next = per_all[i];
          2'd2:    rd_next = duty_all[i];
          default: rd_next = '0;
        endcase
      end
    end
  end

  // One-cycle read latency; a same-cycle write shows up on the following read
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) bus.rdata <= '0;
    else        bus.rdata <= rd_next;
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel.
// A waveform table covers the single-channel modes.
// Hand-written sequences cover buffering, one-shot, resync, reset and the register map.
module tb_pwm_multi_channel;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sync_start = 1'b0;
  logic [3:0] pwm_out, frame_done;
  logic [2:0] pwm3, fd3;
  int         n_tests = 0;
  int         n_fail = 0;

  pwm_multi_channel_if #(.AW(4), .CNT_W(16)) bus ();
  pwm_multi_channel_if #(.AW(4), .CNT_W(16)) bus3 ();

  pwm_multi_channel #(.NUM_CH(4), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus), .sync_start(sync_start),
    .pwm_out(pwm_out), .frame_done(frame_done));

  pwm_multi_channel #(.NUM_CH(3), .CNT_W(16)) dut3 (
    .clk(clk), .n_rst(n_rst), .bus(bus3), .sync_start(sync_start),
    .pwm_out(pwm3), .frame_done(fd3));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          ch;
    logic [15:0] per;
    logic [15:0] duty;
    logic [3:0]  ctrl;
    logic [23:0] exp_pwm;  // bit k = sample k, k=0 is the first negedge after the edge following the CTRL write
    logic [23:0] exp_fd;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; bus.wen = 1'b0; sync_start = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wr(input int ch, input int sel, input logic [15:0] d);
    @(negedge clk);
    bus.wen = 1'b1; bus.waddr = 4'(ch * 4 + sel); bus.wdata = d;
    @(negedge clk);
    bus.wen = 1'b0;
  endtask

  task automatic rd(input int ch, input int sel, output logic [15:0] v);
    @(negedge clk);
    bus.raddr = 4'(ch * 4 + sel);
    @(negedge clk);
    v = bus.rdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] capp, capf;
    logic [32:0] cap;
    logic [15:0] v;
    int          hi, fdn;
    logic [3:0]  acc;

    vecs[0] = '{"left_p10_d3",    0, 16'd10, 16'd3,  4'b0001, 24'hE0380E, 24'h100400};
    vecs[1] = '{"center_pol",     1, 16'd10, 16'd4,  4'b0111, 24'hFC3F0F, 24'h100400};
    vecs[2] = '{"duty_zero",      2, 16'd10, 16'd0,  4'b0001, 24'h000000, 24'h100400};
    vecs[3] = '{"duty_over",      2, 16'd10, 16'd20, 4'b0001, 24'hFFFFFE, 24'h100400};
    vecs[4] = '{"period_zero",    3, 16'd0,  16'd5,  4'b0001, 24'h000000, 24'h000000};
    vecs[5] = '{"one_shot",       3, 16'd5,  16'd5,  4'b1001, 24'h00003E, 24'h000020};
    vecs[6] = '{"disabled_pol",   1, 16'd10, 16'd3,  4'b0010, 24'hFFFFFF, 24'h000000};
    vecs[7] = '{"center_p8_d3",   0, 16'd8,  16'd3,  4'b0101, 24'h383838, 24'h010100};

    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    bus3.wen = 1'b0; bus3.waddr = '0; bus3.wdata = '0; bus3.raddr = '0;

    // Reset state
    #12;
    check("rst_pwm", 64'(pwm_out), 64'h0);
    check("rst_fd", 64'(frame_done), 64'h0);
    check("rst_rdata", 64'(bus.rdata), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Waveform table
    for (int r = 0; r < 8; r++) begin
      do_reset();
      wr(vecs[r].ch, 1, vecs[r].per);
      wr(vecs[r].ch, 2, vecs[r].duty);
      wr(vecs[r].ch, 0, 16'(vecs[r].ctrl));
      for (int k = 0; k < 24; k++) begin
        @(negedge clk);
        capp[k] = pwm_out[vecs[r].ch];
        capf[k] = frame_done[vecs[r].ch];
      end
      check({vecs[r].name, "_pwm"}, 64'(capp), 64'(vecs[r].exp_pwm));
      check({vecs[r].name, "_fd"}, 64'(capf), 64'(vecs[r].exp_fd));
    end

    // Register map, reserved select, same-cycle read/write
    do_reset();
    wr(2, 1, 16'h1234);
    rd(2, 1, v);  check("rd_period", 64'(v), 64'h1234);
    wr(2, 3, 16'hBEEF);
    rd(2, 3, v);  check("rd_reserved", 64'(v), 64'h0);
    wr(1, 0, 16'hFFF5);
    rd(1, 0, v);  check("rd_ctrl_mask", 64'(v), 64'h5);
    wr(1, 2, 16'h0011);
    @(negedge clk);
    bus.wen = 1'b1; bus.waddr = 4'(1 * 4 + 2); bus.raddr = 4'(1 * 4 + 2); bus.wdata = 16'h0055;
    @(negedge clk);
    bus.wen = 1'b0;
    check("rw_same_old", 64'(bus.rdata), 64'h11);
    @(negedge clk);
    check("rw_same_new", 64'(bus.rdata), 64'h55);

    // Channel index beyond NUM_CH on the 3-channel instance
    @(negedge clk);
    bus3.wen = 1'b1; bus3.waddr = 4'(3 * 4 + 1); bus3.wdata = 16'h0077;
    @(negedge clk);
    bus3.waddr = 4'(2 * 4 + 1); bus3.wdata = 16'h0066;
    @(negedge clk);
    bus3.wen = 1'b0; bus3.raddr = 4'(3 * 4 + 1);
    @(negedge clk);
    check("rd_ch_oob", 64'(bus3.rdata), 64'h0);
    bus3.raddr = 4'(2 * 4 + 1);
    @(negedge clk);
    check("rd_ch2_of3", 64'(bus3.rdata), 64'h66);

    // Double buffer: mid-frame duty write, then a write exactly on the wrap cycle
    do_reset();
    wr(2, 1, 16'd8);
    wr(2, 2, 16'd2);
    wr(2, 0, 16'd1);
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      cap[k] = pwm_out[2];
      bus.wen   = (k == 3) || (k == 15);
      bus.waddr = 4'(2 * 4 + 2);
      bus.wdata = (k == 3) ? 16'd6 : 16'd3;
    end
    bus.wen = 1'b0;
    for (int f = 0; f < 4; f++) begin
      hi = 0;
      for (int j = 1; j <= 8; j++) hi += int'(cap[8 * f + j]);
      case (f)
        0: check("dbuf_frame0", 64'(hi), 64'd2);
        1: check("dbuf_frame1", 64'(hi), 64'd6);
        2: check("dbuf_frame2_deferred", 64'(hi), 64'd6);
        default: check("dbuf_frame3", 64'(hi), 64'd3);
      endcase
    end

    // One-shot: five high cycles, one pulse, enable bit self-clears
    do_reset();
    wr(3, 1, 16'd5);
    wr(3, 2, 16'd5);
    wr(3, 0, 16'd9);
    hi = 0; fdn = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      hi  += int'(pwm_out[3]);
      fdn += int'(frame_done[3]);
    end
    check("oneshot_high", 64'(hi), 64'd5);
    check("oneshot_fd", 64'(fdn), 64'd1);
    rd(3, 0, v);
    check("oneshot_ctrl", 64'(v), 64'h8);

    // Resync two phase-offset channels, landing on ch0's wrap edge
    do_reset();
    wr(0, 1, 16'd10); wr(0, 2, 16'd3);
    wr(1, 1, 16'd10); wr(1, 2, 16'd3);
    wr(0, 0, 16'd1);
    wr(1, 0, 16'd1);
    repeat (8) @(negedge clk);
    sync_start = 1'b1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      sync_start = 1'b0;
      check("sync_fd", 64'(frame_done[1:0]), (j == 10) ? 64'h3 : 64'h0);
      if (j >= 1)
        check("sync_pwm", 64'(pwm_out[1:0]),
              ((j >= 1 && j <= 3) || j == 11) ? 64'h3 : 64'h0);
    end

    // Asynchronous reset mid-frame, then nothing runs until re-enabled
    n_rst = 1'b0;
    #1;
    check("async_rst_pwm", 64'(pwm_out), 64'h0);
    check("async_rst_fd", 64'(frame_done), 64'h0);
    @(negedge clk);
    n_rst = 1'b1;
    rd(0, 1, v);  check("rst_period_cleared", 64'(v), 64'h0);
    rd(0, 0, v);  check("rst_ctrl_cleared", 64'(v), 64'h0);
    acc = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      acc |= pwm_out | frame_done;
    end
    check("post_rst_idle", 64'(acc), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
